tdm_demultiplexer_4ch: RTL

//  Receive-side counterpart of the 4-to-1 multiplexer path: takes a time-division-multiplexed

---
 rtl/tdm_demultiplexer_4ch.sv | 101 ++++++++++
 1 files changed

// File: rtl/tdm_demultiplexer_4ch.sv
// Rebuilds four parallel channels from a slot-0-flagged TDM stream.
// Only complete frames are published on out_data, each with a one-cycle out_valid pulse.
module tdm_demultiplexer_4ch #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sync,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err
);

    // state  | meaning
    // HUNT   | waiting for an in_sync beat; unflagged beats are dropped
    // LOCKED | aligned; slot tracks the channel of the next accepted beat
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [1:0]         slot_nxt;
    logic [WIDTH-1:0]   shadow     [0:2];
    logic [WIDTH-1:0]   shadow_nxt [0:2];
    logic [4*WIDTH-1:0] out_data_nxt;
    logic               valid_nxt;
    logic               err_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            slot      <= 2'd0;
            shadow    <= '{default: '0};
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            shadow    <= shadow_nxt;
            out_data  <= out_data_nxt;
            out_valid <= valid_nxt;
            sync_err  <= err_nxt;
            locked    <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        shadow_nxt   = shadow;
        out_data_nxt = out_data;
        valid_nxt    = 1'b0;
        err_nxt      = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sync) begin
                        shadow_nxt[0] = in_data;
                        slot_nxt      = 2'd1;
                        state_nxt     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync) begin
                        // A sync beat mid-frame restarts the frame at slot 0.
                        err_nxt       = (slot != 2'd0);
                        shadow_nxt[0] = in_data;
                        slot_nxt      = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                err_nxt   = 1'b1;
                                state_nxt = HUNT;
                                slot_nxt  = 2'd0;
                            end
                            2'd1: begin
                                shadow_nxt[1] = in_data;
                                slot_nxt      = 2'd2;
                            end
                            2'd2: begin
                                shadow_nxt[2] = in_data;
                                slot_nxt      = 2'd3;
                            end
                            default: begin
                                out_data_nxt = {in_data, shadow[2], shadow[1], shadow[0]};
                                valid_nxt    = 1'b1;
                                slot_nxt     = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

endmodule
